instr_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the CPU datapath/control pair.
- Owns the program counter and issues requests to instruction memory.
- Buffers returned 16-bit instructions in a small in-order queue and presents them, with their PC, to the decode/datapath stage over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from downstream and flushes stale work.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/instr_fetch_unit_fetch_queue.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the fetch stage and its queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'd10;
    localparam logic [ADDR_W-1:0] PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Sequential successor of a fetch address; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] seqPc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Purpose: in-order FIFO of fetched {instr, pc} entries with synchronous flush.
// Latency: a push is visible at head on the next cycle; head is a register read.
// Backpressure: none internally; the caller must never push into a full queue.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int CNT_W = $clog2(QDEPTH + 1),
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       pushEntry,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t       mem [QDEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic [CNT_W-1:0]   cnt;
    logic               doPush;
    logic               doPop;
    logic               full;

    // Flush wins over push; a pop on an empty queue is ignored.
    assign doPush = push && !flush;
    assign doPop  = pop && !flush && (cnt != '0);
    assign full   = (cnt == CNT_W'(QDEPTH));

    assign count = cnt;
    assign head  = mem[rdPtr];

    // Storage, pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= (wrPtr == PTR_W'(QDEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= (rdPtr == PTR_W'(QDEPTH - 1)) ? '0 : rdPtr + 1'b1;
            end
            cnt <= cnt + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

`ifndef SYNTHESIS
    // The fetch credit rule must keep us from ever pushing into a full queue.
    noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !pop && full));
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, issues instruction-memory fetches, queues responses for decode.
// Latency: grant -> id_valid is 2 cycles minimum (1-cycle memory + queue register).
// Backpressure: new fetches stall while outstanding + queued reaches QDEPTH.
// Optional: define FETCH_PERF_EN to add stall/flush performance counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_stall_cnt,
    output logic [15:0]        perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fetch_state_t       state;
    fetch_state_t       stateNext;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;
    logic [CNT_W-1:0]   discardNext;

    logic [ADDR_W-1:0]  tagMem [QDEPTH];
    logic [PTR_W-1:0]   tagRd;
    logic [PTR_W-1:0]   tagWr;

    logic               grant;
    logic               rspDec;
    logic               qPush;
    logic               qPop;
    logic               qFlush;
    logic [CNT_W-1:0]   queueCount;
    fetch_entry_t       queueHead;
    fetch_entry_t       pushEntry;

    assign grant     = imem_req && imem_gnt;
    // Every response retires one outstanding request, whether kept or dropped.
    assign rspDec    = imem_rvalid && (outstanding != '0);
    assign imem_addr = pc;

    assign pushEntry = '{instr: imem_rdata, pc: tagMem[tagRd]};
    assign qPop      = id_valid && id_ready;
    assign qFlush    = redirect_valid;

    assign id_valid  = (queueCount != '0);
    assign id_instr  = queueHead.instr;
    assign id_pc     = queueHead.pc;

    // Next state, fetch request and response routing.
    always_comb begin
        stateNext   = state;
        discardNext = discard;
        imem_req    = 1'b0;
        qPush       = 1'b0;

        case (state)
            BOOT: begin
                stateNext = RUN;
            end
            RUN: begin
                imem_req = !redirect_valid &&
                           ((int'(outstanding) + int'(queueCount)) < QDEPTH);
                qPush    = imem_rvalid && !redirect_valid;
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    discardNext = discard - 1'b1;
                    if (discard == CNT_W'(1)) begin
                        stateNext = RUN;
                    end
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase

        // imem_req is held low on a redirect, so no grant can land in this
        // cycle; the stale count is simply what remains after this cycle's
        // response (which is itself dropped).
        if (redirect_valid) begin
            discardNext = outstanding - CNT_W'(rspDec);
            if (state != BOOT) begin
                stateNext = (discardNext != '0) ? DRAIN : RUN;
            end
        end
    end

    // State register and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            discard <= '0;
        end else begin
            state   <= stateNext;
            discard <= discardNext;
        end
    end

    // Program counter: redirect overrides sequential advance on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (grant) begin
            pc <= seqPc(pc);
        end
    end

    // Outstanding-request credit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rspDec);
        end
    end

    // Tag ring: PC captured at grant, consumed in order by each response so
    // stale responses still retire their own tag during a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagRd <= '0;
            tagWr <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                tagMem[i] <= '0;
            end
        end else begin
            if (grant) begin
                tagMem[tagWr] <= pc;
                tagWr         <= (tagWr == PTR_W'(QDEPTH - 1)) ? '0 : tagWr + 1'b1;
            end
            if (rspDec) begin
                tagRd <= (tagRd == PTR_W'(QDEPTH - 1)) ? '0 : tagRd + 1'b1;
            end
        end
    end

    fetch_queue #(
        .QDEPTH    (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (qPush),
        .pushEntry (pushEntry),
        .pop       (qPop),
        .flush     (qFlush),
        .count     (queueCount),
        .head      (queueHead)
    );

`ifdef FETCH_PERF_EN
    // Saturating counters: decode starved outside BOOT, and redirects seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((state != BOOT) && id_ready && !id_valid && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
            if (redirect_valid && (perf_flush_cnt != 16'hFFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    tagOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(grant && !rspDec && (outstanding == CNT_W'(QDEPTH))));
    orphanResponse: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (outstanding == '0)));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: randomized scoreboard bench for instr_fetch_unit against a program-order model.
// Latency: expects first id_valid two cycles after the first grant.
// Backpressure: drives random grant, response delay and id_ready.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8]} + 16'h1357;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Program-order model: the decode stage must see a contiguous PC stream
    // starting at the reset PC or the latest redirect target.
    typedef struct { logic [15:0] pc; logic [15:0] instr; } exp_t;
    exp_t        expQ[$];
    exp_t        mE;
    logic [15:0] genPc = 16'd10;
    bit          redirPending = 0;
    logic [15:0] redirTarget = 16'h0;

    // Memory model: in-order responses, random grant and delay (>= 1 cycle).
    typedef struct { logic [15:0] addr; int rdy; } mreq_t;
    mreq_t memQ[$];
    int    gntPct = 100;
    int    respPct = 100;
    bit    holdResp = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            memQ.delete();
        end else begin
            if (imem_rvalid && memQ.size() > 0) memQ.delete(0);
            if (imem_req && imem_gnt) memQ.push_back('{imem_addr, cyc + 1});
        end
    end

    always @(posedge clk) begin
        #1;
        imem_gnt = ($urandom_range(99) < gntPct);
        if (rst_n && memQ.size() > 0 && !holdResp && memQ[0].rdy <= cyc &&
            $urandom_range(99) < respPct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memQ[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'hDEAD;
        end
    end

    // Monitor: request addresses follow the fetch stream; pops match the scoreboard.
    logic [15:0] reqExpPc = 16'd10;
    logic [15:0] lastGrantAddr = 16'h0;
    bit          wrapSeen = 0;
    int          grantCnt = 0;
    int          popCnt = 0;
    int          firstGrantCyc = -1;
    int          firstValidCyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            reqExpPc = 16'd10;
        end else begin
            if (imem_req && imem_gnt) begin
                check("req_addr", imem_addr, reqExpPc);
                if (imem_addr == 16'h0000 && lastGrantAddr == 16'hFFFE) wrapSeen = 1;
                lastGrantAddr = imem_addr;
                reqExpPc = reqExpPc + 16'd2;
                grantCnt++;
                if (firstGrantCyc < 0) firstGrantCyc = cyc;
            end
            if (id_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (redirect_valid) check("req_in_redirect", imem_req, 0);
            if (id_valid && id_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL id_out: got pc %0h want no output", id_pc);
                end else begin
                    mE = expQ.pop_front();
                    check("id_pc", id_pc, mE.pc);
                    check("id_instr", id_instr, mE.instr);
                end
                popCnt++;
            end
            if (redirect_valid) reqExpPc = redirect_pc;
        end
    end

    task automatic topUp();
        while (expQ.size() < 4) begin
            expQ.push_back('{genPc, memWord(genPc)});
            genPc = genPc + 16'd2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (redirPending) begin
            expQ.delete();
            genPc = redirTarget;
            redirPending = 0;
        end
        topUp();
    endtask

    task automatic issueRedirect(input logic [15:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        redirPending   = 1;
        redirTarget    = t;
        tick();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 16'd10);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 0);
        check("rst_id_pc", id_pc, 0);
`ifdef FETCH_PERF_EN
        check("rst_perf_stall", perf_stall_cnt, 0);
        check("rst_perf_flush", perf_flush_cnt, 0);
`endif
        expQ.delete();
        genPc = 16'd10;
        redirPending = 0;
        topUp();
        repeat (2) tick();
        grantCnt = 0;
        firstGrantCyc = -1;
        firstValidCyc = -1;
        rst_n = 1'b1;
    endtask

    task automatic waitPops(input int n, input int budget);
        int target = popCnt + n;
        int k = 0;
        while (popCnt < target && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (popCnt < target) begin
            bad++;
            $display("FAIL pop_timeout: got %0d pops want %0d", popCnt, target);
        end
    endtask

    int relCyc;
    int p0;
    logic [15:0] tgt;

    initial begin
        rst_n = 1'b1;
        tick();

        // Reset values, BOOT cycle, and grant -> id_valid latency.
        gntPct = 100; respPct = 100; holdResp = 0; id_ready = 1'b1;
        doReset();
        relCyc = cyc;
        @(negedge clk);
        check("boot_no_req", imem_req, 0);
        waitPops(8, 60);
        check("boot_one_cycle", firstGrantCyc, relCyc + 1);
        check("grant_to_valid", firstValidCyc - firstGrantCyc, 2);

        // Decode stalled: two requests fill the queue, then fetch stops.
        id_ready = 1'b0;
        doReset();
        repeat (12) tick();
        check("stall_grants", grantCnt, 2);
        @(negedge clk);
        check("stall_req_low", imem_req, 0);
        check("stall_valid", id_valid, 1);
        check("stall_head_pc", id_pc, 16'd10);
        tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        repeat (6) tick();
        check("refill_one", grantCnt, 3);

        // Redirect with nothing outstanding: request at the target next cycle.
        issueRedirect(16'h0040);
        @(negedge clk);
        check("redir_next_req", imem_req, 1);
        check("redir_next_addr", imem_addr, 16'h0040);
        tick();
        id_ready = 1'b1;
        waitPops(4, 40);

        // Redirect with two requests outstanding: stale responses dropped.
        holdResp = 1;
        doReset();
        repeat (6) tick();
        check("drain_grants", grantCnt, 2);
        issueRedirect(16'h0100);
        @(negedge clk);
        check("drain_req_low", imem_req, 0);
        tick();
        holdResp = 0;
        waitPops(4, 60);

        // Sequential fetch across the top of the address space.
        wrapSeen = 0;
        issueRedirect(16'hFFFC);
        waitPops(6, 60);
        check("pc_wrap", wrapSeen, 1);

        // Random grant, response delay, backpressure and redirects.
        gntPct = 60; respPct = 50;
        p0 = popCnt;
        for (int i = 0; i < 2500; i++) begin
            id_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) begin
                if ($urandom_range(3) == 0) tgt = 16'hFFF8 + 16'($urandom_range(3) * 2);
                else tgt = 16'($urandom) & 16'hFFFE;
                issueRedirect(tgt);
            end else begin
                tick();
            end
        end
        check("random_progress", (popCnt - p0) >= 300, 1);

        // Reset in the middle of a full-queue burst.
        gntPct = 100; respPct = 100; id_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("pre_reset_valid", id_valid, 1);
        tick();
        doReset();
        id_ready = 1'b1;
        waitPops(4, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want test end");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
